// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and stage bundles for the DE->AGEX hazard controller.
package hazard_ctrl_pkg;

  localparam int NUM_REGS  = 32;
  localparam int REGNOBITS = 5;
  localparam int CNT_BITS  = 2;   // up to 3 in-flight writes: AGEX, MEM, WB latches
  localparam int DBITS     = 32;

  localparam int HZ_CNT_BITS = CNT_BITS;

  // DE-side view: {valid, use_rs1, use_rs2, wr_reg, rs1, rs2, wregno}
  typedef struct packed {
    logic                 valid;
    logic                 use_rs1;
    logic                 use_rs2;
    logic                 wr_reg;
    logic [REGNOBITS-1:0] rs1;
    logic [REGNOBITS-1:0] rs2;
    logic [REGNOBITS-1:0] wregno;
  } from_de_t;

  // WB-side view: {valid, wr_reg, wregno}
  typedef struct packed {
    logic                 valid;
    logic                 wr_reg;
    logic [REGNOBITS-1:0] wregno;
  } from_wb_t;

  localparam int FROM_DE_BITS = $bits(from_de_t);
  localparam int FROM_WB_BITS = $bits(from_wb_t);

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register in-flight write counters between DE issue and WB retire.
// x0 is never tracked. A retire against an empty counter sets a sticky error.
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc_i,
  input  logic [REGNOBITS-1:0] inc_regno_i,
  input  logic                 dec_i,
  input  logic [REGNOBITS-1:0] dec_regno_i,
  output logic [NUM_REGS-1:0]  busy_o,
  output logic [NUM_REGS-1:0]  full_o,
  output logic                 sb_err_o
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [CNT_BITS-1:0] cnt_q [NUM_REGS];
  logic [CNT_BITS-1:0] cnt_d [NUM_REGS];
  logic                err_q;
  logic                err_d;
  logic [NUM_REGS-1:0] inc_sel_s;
  logic [NUM_REGS-1:0] dec_sel_s;

  // Decode issue/retire requests into one-hot register selects, excluding x0.
  always_comb begin
    inc_sel_s = '0;
    dec_sel_s = '0;
    if (inc_i && (inc_regno_i != '0)) begin
      inc_sel_s[inc_regno_i] = 1'b1;
    end else begin
      inc_sel_s = '0;
    end
    if (dec_i && (dec_regno_i != '0)) begin
      dec_sel_s[dec_regno_i] = 1'b1;
    end else begin
      dec_sel_s = '0;
    end
  end

  // Next counter values: simultaneous inc/dec cancel, no wrap in either direction.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      case ({inc_sel_s[r], dec_sel_s[r]})
        2'b10: begin
          if (cnt_q[r] != CNT_MAX) cnt_d[r] = cnt_q[r] + CNT_BITS'(1);
          else                     cnt_d[r] = cnt_q[r];
        end
        2'b01: begin
          if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - CNT_BITS'(1);
          else                cnt_d[r] = cnt_q[r];
        end
        default: cnt_d[r] = cnt_q[r];
      endcase
    end
    err_d = err_q | (|(dec_sel_s & ~busy_o));
  end

  // Status bits seen by the issue logic.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_o[r] = (cnt_q[r] != '0);
      full_o[r] = (cnt_q[r] == CNT_MAX);
    end
  end

  // Counter and sticky-error state; reset discards all in-flight tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign sb_err_o = err_q;

endmodule

// File: rtl/hazard_ctrl.sv
// DE->AGEX issue controller: RAW/overflow stall, mispredict flush, perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 de_valid,
  input  logic [REGNOBITS-1:0] de_rs1,
  input  logic [REGNOBITS-1:0] de_rs2,
  input  logic                 de_use_rs1,
  input  logic                 de_use_rs2,
  input  logic                 de_wr_reg,
  input  logic [REGNOBITS-1:0] de_wregno,
  input  logic                 agex_br_mispred,
  input  logic                 wb_valid,
  input  logic                 wb_wr_reg,
  input  logic [REGNOBITS-1:0] wb_wregno,
  output logic                 stall_de,
  output logic                 flush_de,
  output logic                 de_issue,
  output logic [DBITS-1:0]     stall_cnt,
  output logic [DBITS-1:0]     flush_cnt,
  output logic                 sb_err
);

  from_de_t            de_s;
  from_wb_t            wb_s;
  logic [NUM_REGS-1:0] busy_s;
  logic [NUM_REGS-1:0] full_s;
  logic                hz_rs1_s;
  logic                hz_rs2_s;
  logic                hz_ovf_s;
  logic                stall_s;
  logic                flush_s;
  logic                issue_s;
  logic [DBITS-1:0]    stall_cnt_q;
  logic [DBITS-1:0]    stall_cnt_d;
  logic [DBITS-1:0]    flush_cnt_q;
  logic [DBITS-1:0]    flush_cnt_d;

  assign de_s = '{valid: de_valid, use_rs1: de_use_rs1, use_rs2: de_use_rs2,
                  wr_reg: de_wr_reg, rs1: de_rs1, rs2: de_rs2, wregno: de_wregno};
  assign wb_s = '{valid: wb_valid, wr_reg: wb_wr_reg, wregno: wb_wregno};

  hazard_scoreboard u_sb (
    .clk         (clk),
    .reset       (reset),
    .inc_i       (issue_s & de_s.wr_reg),
    .inc_regno_i (de_s.wregno),
    .dec_i       (wb_s.valid & wb_s.wr_reg),
    .dec_regno_i (wb_s.wregno),
    .busy_o      (busy_s),
    .full_o      (full_s),
    .sb_err_o    (sb_err)
  );

  // Issue decision; a retiring register still stalls its reader (no WB bypass).
  always_comb begin
    hz_rs1_s = de_s.use_rs1 && (de_s.rs1 != '0) && busy_s[de_s.rs1];
    hz_rs2_s = de_s.use_rs2 && (de_s.rs2 != '0) && busy_s[de_s.rs2];
    hz_ovf_s = de_s.wr_reg && (de_s.wregno != '0) && full_s[de_s.wregno];
    if (reset) begin
      flush_s = 1'b0;
      stall_s = 1'b0;
      issue_s = 1'b0;
    end else begin
      flush_s = agex_br_mispred;
      stall_s = de_s.valid && !flush_s && (hz_rs1_s || hz_rs2_s || hz_ovf_s);
      issue_s = de_s.valid && !stall_s && !flush_s;
    end
  end

  // Next performance-counter values, wrapping naturally.
  always_comb begin
    stall_cnt_d = stall_cnt_q + (stall_s ? DBITS'(1) : DBITS'(0));
    flush_cnt_d = flush_cnt_q + (flush_s ? DBITS'(1) : DBITS'(0));
  end

  // Performance-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_de  = stall_s;
  assign flush_de  = flush_s;
  assign de_issue  = issue_s;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard-style bench for hazard_ctrl: a reference model computes the
// expected outputs each cycle, pushes them to a queue, and the sampled DUT
// outputs are compared against the popped entry.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic                 de_valid, de_use_rs1, de_use_rs2, de_wr_reg;
  logic [REGNOBITS-1:0] de_rs1, de_rs2, de_wregno;
  logic                 agex_br_mispred;
  logic                 wb_valid, wb_wr_reg;
  logic [REGNOBITS-1:0] wb_wregno;
  logic                 stall_de, flush_de, de_issue, sb_err;
  logic [DBITS-1:0]     stall_cnt, flush_cnt;

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
    .de_use_rs1(de_use_rs1), .de_use_rs2(de_use_rs2), .de_wr_reg(de_wr_reg),
    .de_wregno(de_wregno), .agex_br_mispred(agex_br_mispred), .wb_valid(wb_valid),
    .wb_wr_reg(wb_wr_reg), .wb_wregno(wb_wregno), .stall_de(stall_de),
    .flush_de(flush_de), .de_issue(de_issue), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .sb_err(sb_err)
  );

  typedef struct packed {
    logic             stall;
    logic             flush;
    logic             issue;
    logic [DBITS-1:0] scnt;
    logic [DBITS-1:0] fcnt;
    logic             err;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          m_cnt[NUM_REGS];
  logic [DBITS-1:0] m_scnt, m_fcnt;
  logic        m_err;

  task automatic check(input string tag, input logic [DBITS-1:0] got, input logic [DBITS-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: hold the given inputs, compare at negedge, update model at posedge.
  task automatic step(input logic v, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic wr,
                      input logic [4:0] wreg, input logic mp,
                      input logic wbv, input logic [4:0] wbreg);
    exp_t e, g;
    logic h1, h2, ovf, inc, dec;
    de_valid = v; de_rs1 = rs1; de_use_rs1 = u1; de_rs2 = rs2; de_use_rs2 = u2;
    de_wr_reg = wr; de_wregno = wreg; agex_br_mispred = mp;
    wb_valid = wbv; wb_wr_reg = wbv; wb_wregno = wbreg;
    @(negedge clk);
    h1  = u1 && (rs1 != 5'd0) && (m_cnt[rs1] != 0);
    h2  = u2 && (rs2 != 5'd0) && (m_cnt[rs2] != 0);
    ovf = wr && (wreg != 5'd0) && (m_cnt[wreg] == 3);
    e.flush = !reset && mp;
    e.stall = !reset && v && !mp && (h1 || h2 || ovf);
    e.issue = !reset && v && !e.stall && !e.flush;
    e.scnt  = m_scnt;
    e.fcnt  = m_fcnt;
    e.err   = m_err;
    exp_q.push_back(e);
    g = exp_q.pop_front();
    check("stall_de",  {{(DBITS-1){1'b0}}, stall_de}, {{(DBITS-1){1'b0}}, g.stall});
    check("flush_de",  {{(DBITS-1){1'b0}}, flush_de}, {{(DBITS-1){1'b0}}, g.flush});
    check("de_issue",  {{(DBITS-1){1'b0}}, de_issue}, {{(DBITS-1){1'b0}}, g.issue});
    check("stall_cnt", stall_cnt, g.scnt);
    check("flush_cnt", flush_cnt, g.fcnt);
    check("sb_err",    {{(DBITS-1){1'b0}}, sb_err},   {{(DBITS-1){1'b0}}, g.err});
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) m_cnt[r] = 0;
      m_scnt = '0; m_fcnt = '0; m_err = 1'b0;
    end else begin
      inc = e.issue && wr && (wreg != 5'd0);
      dec = wbv && (wbreg != 5'd0);
      if (dec && (m_cnt[wbreg] == 0)) m_err = 1'b1;
      if (inc && dec && (wreg == wbreg)) begin
        // issue and retire of the same register cancel
      end else begin
        if (inc) m_cnt[wreg] = m_cnt[wreg] + 1;
        if (dec && (m_cnt[wbreg] != 0)) m_cnt[wbreg] = m_cnt[wbreg] - 1;
      end
      if (e.stall) m_scnt = m_scnt + 1;
      if (e.flush) m_fcnt = m_fcnt + 1;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
  endtask

  // Two reset cycles with a valid instruction presented in DE.
  task automatic do_reset();
    reset = 1'b1;
    step(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 5'd4);
    step(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0);
    reset = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < NUM_REGS; r++) m_cnt[r] = 0;
    m_scnt = '0; m_fcnt = '0; m_err = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    // Reset behaviour
    do_reset();
    idle();
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_sb_err", {31'd0, sb_err}, 32'd0);

    // RAW on x5: issue write, reader stalls through the WB retire cycle
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0);
    step(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5);
    step(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    idle();
    check("raw_stall_cnt", stall_cnt, 32'd3);

    // x0 is never tracked
    do_reset();
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0);
    idle();
    check("x0_stall_cnt", stall_cnt, 32'd0);

    // Mispredict with a RAW hazard present: flush wins, x7 not tracked
    do_reset();
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 5'd0);
    step(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0);
    step(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4);
    idle();
    check("mp_flush_cnt", flush_cnt, 32'd1);
    check("mp_stall_cnt", stall_cnt, 32'd0);

    // WAW on x3 up to the overflow guard, then simultaneous issue/retire
    do_reset();
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0);
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0);
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 5'd3);
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 5'd3);
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0);
    step(1'b1, 5'd3, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3);

    // Reset mid-operation with x3 busy, then underflow on x9
    do_reset();
    step(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9);
    idle();
    idle();
    check("uf_sb_err", {31'd0, sb_err}, 32'd1);
    do_reset();
    idle();
    check("uf_sb_err_clr", {31'd0, sb_err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
